// File: rtl/pep_mmacc_gram_arb_if.sv
// Request/grant bundle between the MMACC GRAM requesters and the per-bank
// GRAM arbiter. Requesters drive the per-bank request vectors and the freeze
// control; the arbiter returns the packed one-hot grants and per-bank busy.
interface pep_mmacc_gram_arb_if #(
  parameter int GRAM_NB = 4
);
  localparam int GARB_AVAIL_1H_W = 6 * GRAM_NB;

  logic [GRAM_NB-1:0]         ldg_req;
  logic [GRAM_NB-1:0]         sxt_req;
  logic [GRAM_NB-1:0]         acc_wr_req;
  logic [GRAM_NB-1:0]         acc_rd_req;
  logic [GRAM_NB-1:0]         feed_dat_req;
  logic [GRAM_NB-1:0]         feed_rot_req;
  logic                       arb_freeze;
  logic [GARB_AVAIL_1H_W-1:0] garb_avail_1h;
  logic [GRAM_NB-1:0]         garb_busy;

  // Requester side: raises requests, observes grants.
  modport master (
    output ldg_req, sxt_req, acc_wr_req, acc_rd_req, feed_dat_req, feed_rot_req,
    output arb_freeze,
    input  garb_avail_1h, garb_busy
  );

  // Arbiter side: samples requests, issues grants.
  modport slave (
    input  ldg_req, sxt_req, acc_wr_req, acc_rd_req, feed_dat_req, feed_rot_req,
    input  arb_freeze,
    output garb_avail_1h, garb_busy
  );
endinterface

// File: rtl/pep_mmacc_gram_arb.sv
// Per-GRAM-bank arbiter for the MMACC GLWE RAM. Each bank has its own
// round-robin arbiter over six requester classes with a bounded burst length:
// an owner keeps the bank while it requests, but once it has held it for
// MAX_BURST cycles while someone else waits, the bank is handed over.
// Grants are registered; there is no combinational path from req to grant.
module pep_mmacc_gram_arb #(
  parameter int GRAM_NB   = 4,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  pep_mmacc_gram_arb_if.slave   arb_if
);

  localparam int NB_CLASS        = 6;
  localparam int GARB_AVAIL_1H_W = NB_CLASS * GRAM_NB;

  // Round-robin search: first set bit of req after ptr, wrapping over 0..5.
  // Returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [NB_CLASS-1:0] req,
                                         input logic [2:0]          ptr);
    logic [7:0] req8;
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    req8  = {2'b00, req};
    idx   = ptr;
    win   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < NB_CLASS; i++) begin
      if (idx >= 3'd5) begin
        idx = 3'd0;
      end else begin
        idx = idx + 3'd1;
      end
      if (!found && req8[idx]) begin
        found = 1'b1;
        win   = idx;
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  logic [NB_CLASS-1:0]        req_s       [GRAM_NB];
  logic                       owner_vld_q [GRAM_NB];
  logic                       owner_vld_d [GRAM_NB];
  logic [2:0]                 owner_q     [GRAM_NB];
  logic [2:0]                 owner_d     [GRAM_NB];
  logic [CNT_W-1:0]           burst_cnt_q [GRAM_NB];
  logic [CNT_W-1:0]           burst_cnt_d [GRAM_NB];
  logic [2:0]                 rr_ptr_q    [GRAM_NB];
  logic [2:0]                 rr_ptr_d    [GRAM_NB];
  logic [GARB_AVAIL_1H_W-1:0] garb_avail_1h_q;
  logic [GARB_AVAIL_1H_W-1:0] garb_avail_1h_d;
  logic [GRAM_NB-1:0]         garb_busy_q;
  logic [GRAM_NB-1:0]         garb_busy_d;

  // Gather the six class requests of each bank, class index = bit position.
  always_comb begin
    for (int g = 0; g < GRAM_NB; g++) begin
      req_s[g] = {arb_if.feed_rot_req[g], arb_if.feed_dat_req[g],
                  arb_if.acc_rd_req[g],   arb_if.acc_wr_req[g],
                  arb_if.sxt_req[g],      arb_if.ldg_req[g]};
    end
  end

  // Per-bank next-state: idle pick, release handover, burst count, preemption.
  always_comb begin
    logic [NB_CLASS-1:0] others;
    logic [3:0]          pick;
    others = '0;
    pick   = 4'd0;
    for (int g = 0; g < GRAM_NB; g++) begin
      owner_vld_d[g] = owner_vld_q[g];
      owner_d[g]     = owner_q[g];
      burst_cnt_d[g] = burst_cnt_q[g];
      rr_ptr_d[g]    = rr_ptr_q[g];
      others         = req_s[g] & ~(6'b000001 << owner_q[g]);
      if (arb_if.arb_freeze) begin
        // Frozen: everything holds, requests are ignored.
        owner_vld_d[g] = owner_vld_q[g];
      end else if (!owner_vld_q[g]) begin
        pick = rr_pick(req_s[g], rr_ptr_q[g]);
        if (pick[3]) begin
          owner_vld_d[g] = 1'b1;
          owner_d[g]     = pick[2:0];
          rr_ptr_d[g]    = pick[2:0];
          burst_cnt_d[g] = CNT_W'(1);
        end else begin
          owner_vld_d[g] = 1'b0;
        end
      end else if (!req_s[g][owner_q[g]]) begin
        // Owner released: hand over without a bubble, or go idle.
        pick = rr_pick(others, rr_ptr_q[g]);
        if (pick[3]) begin
          owner_d[g]     = pick[2:0];
          rr_ptr_d[g]    = pick[2:0];
          burst_cnt_d[g] = CNT_W'(1);
        end else begin
          owner_vld_d[g] = 1'b0;
          burst_cnt_d[g] = '0;
        end
      end else if (others == 6'b000000) begin
        // Solo owner: keep the bank, counter saturates.
        if (burst_cnt_q[g] < CNT_W'(MAX_BURST)) begin
          burst_cnt_d[g] = burst_cnt_q[g] + CNT_W'(1);
        end else begin
          burst_cnt_d[g] = burst_cnt_q[g];
        end
      end else if (burst_cnt_q[g] < CNT_W'(MAX_BURST)) begin
        burst_cnt_d[g] = burst_cnt_q[g] + CNT_W'(1);
      end else begin
        // Burst exhausted with contention: preempt to the next RR class.
        pick = rr_pick(others, rr_ptr_q[g]);
        if (pick[3]) begin
          owner_d[g]     = pick[2:0];
          rr_ptr_d[g]    = pick[2:0];
          burst_cnt_d[g] = CNT_W'(1);
        end else begin
          burst_cnt_d[g] = burst_cnt_q[g];
        end
      end
    end
  end

  // Grant and busy are decoded from next state so they leave the block registered.
  always_comb begin
    garb_avail_1h_d = '0;
    garb_busy_d     = '0;
    for (int g = 0; g < GRAM_NB; g++) begin
      garb_busy_d[g] = owner_vld_d[g];
      if (owner_vld_d[g]) begin
        garb_avail_1h_d[int'(owner_d[g]) * GRAM_NB + g] = 1'b1;
      end else begin
        garb_busy_d[g] = 1'b0;
      end
    end
  end

  // State and output registers; async reset drops all grants at once.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      for (int g = 0; g < GRAM_NB; g++) begin
        owner_vld_q[g] <= 1'b0;
        owner_q[g]     <= 3'd0;
        burst_cnt_q[g] <= '0;
        rr_ptr_q[g]    <= 3'd5;
      end
      garb_avail_1h_q <= '0;
      garb_busy_q     <= '0;
    end else begin
      for (int g = 0; g < GRAM_NB; g++) begin
        owner_vld_q[g] <= owner_vld_d[g];
        owner_q[g]     <= owner_d[g];
        burst_cnt_q[g] <= burst_cnt_d[g];
        rr_ptr_q[g]    <= rr_ptr_d[g];
      end
      garb_avail_1h_q <= garb_avail_1h_d;
      garb_busy_q     <= garb_busy_d;
    end
  end

  assign arb_if.garb_avail_1h = garb_avail_1h_q;
  assign arb_if.garb_busy     = garb_busy_q;

endmodule

// File: doc/pep_mmacc_gram_arb.md
Name: pep_mmacc_gram_arb

Overview:
- Per-GRAM arbiter for the MMACC GLWE RAM (GRAM) banks.
- Six requester classes compete for each bank: ldg, sxt, acc_wr, acc_rd, feed_dat and feed_rot.
- The block issues registered one-hot grants, packed as garb_avail_1h_t, to main and subs.
- Each bank runs independently with round-robin fairness and a bounded burst length, so no requester can starve the others.

Parameters:
- GRAM_NB, 4: number of GRAM banks; one independent arbiter per bank.
- MAX_BURST, 8: maximum consecutive grant cycles an owner keeps while another class is requesting the same bank. Must be >= 1.
- CNT_W, $clog2(MAX_BURST+1): width of the burst counter.

Ports:
- clk  in  1  system clock.
- a_rst_n  in  1  asynchronous active-low reset.
- ldg_req  in  GRAM_NB  per-bank request, load-GLWE.
- sxt_req  in  GRAM_NB  per-bank request, sample extract.
- acc_wr_req  in  GRAM_NB  per-bank request, accumulator write.
- acc_rd_req  in  GRAM_NB  per-bank request, accumulator read.
- feed_dat_req  in  GRAM_NB  per-bank request, feed data read.
- feed_rot_req  in  GRAM_NB  per-bank request, feed rotated read.
- arb_freeze  in  1  while high: current grants hold, burst counters hold, no new grant is issued.
- garb_avail_1h  out  GARB_AVAIL_1H_W (6*GRAM_NB)  packed grant vector. Fields from MSB to LSB: feed_rot, feed_dat, acc_rd, acc_wr, sxt, ldg.
- garb_busy  out  GRAM_NB  bit g = 1 when bank g has any grant.

Behaviour:
- Class index c: ldg=0, sxt=1, acc_wr=2, acc_rd=3, feed_dat=4, feed_rot=5.
- Per bank g, req[c] = <class>_req[g].
- Per-bank state:
  - owner_vld, owner[2:0], burst_cnt[CNT_W-1:0].
  - rr_ptr[2:0]: last winner.
- Reset values (asynchronous): all garb_avail_1h = 0, garb_busy = 0, owner_vld = 0, burst_cnt = 0, rr_ptr = 5 (so the first search starts at ldg).
- Reset asserted mid-burst: grants drop immediately. After release, arbitration restarts from the reset state; no stale grant remains.
- Invariant: at most one bit set among the six fields for any bank g.
- Latency: grant is registered. A request sampled at cycle t gets garb_avail_1h at t+1. The requester must hold req until it sees the grant.
- Next-state decision at each edge (arb_freeze = 0):
  - IDLE (owner_vld = 0):
    - No req: stay IDLE.
    - Otherwise: winner = first set req searching rr_ptr+1, rr_ptr+2, ... mod 6. Set owner = winner, owner_vld = 1, rr_ptr = winner, burst_cnt = 1.
  - OWNED, req[owner] = 0 (release): zero-bubble handover.
    - Other reqs present: pick RR winner (same search) and grant at the next edge.
    - No other req: go IDLE.
  - OWNED, req[owner] = 1, no other req: keep grant. burst_cnt saturates at MAX_BURST.
  - OWNED, req[owner] = 1, other req present:
    - burst_cnt < MAX_BURST: keep grant, burst_cnt += 1.
    - burst_cnt == MAX_BURST: preempt. RR winner among the other classes gets the grant at the next edge; burst_cnt = 1. The preempted class's req stays pending and re-enters RR.
- Any req change in OWNED resets burst_cnt only through the rules above; a new owner always starts at burst_cnt = 1.
- arb_freeze = 1: all per-bank state holds, including burst_cnt and rr_ptr. Requests are ignored. Arbitration resumes on the first edge with arb_freeze = 0, using the requests present at that edge.
- garb_busy[g] = owner_vld[g], registered (same cycle as the grant).
- Banks are fully independent. One class may own several banks simultaneously.
- No combinational path from any req to garb_avail_1h.

Test Plan:
- Reset then single request: ldg_req = 4'b0001 at cycle 0 -> garb_avail_1h.ldg = 4'b0001 at cycle 1; all other bits 0; garb_busy = 4'b0001.
- Simultaneous requests after reset: all six classes request bank 2 continuously, MAX_BURST = 8 -> grant order ldg, sxt, acc_wr, acc_rd, feed_dat, feed_rot, ldg..., each held exactly 8 cycles, no idle cycle between owners.
- Zero-bubble release: sxt owns bank 0, acc_rd_req[0] high; sxt_req[0] drops at cycle t -> acc_rd grant at t+1, sxt grant 0 at t+1.
- Solo owner: feed_rot_req[3] high for 40 cycles, no other requester -> grant held all 40 cycles; burst_cnt saturates at 8; no preemption.
- Freeze: acc_wr owns bank 1 at burst_cnt = 3; arb_freeze high 10 cycles while ldg requests bank 1 -> acc_wr keeps the grant, burst_cnt stays 3. After freeze drops, preemption occurs 5 cycles later.
- Async reset mid-burst: a_rst_n low in the middle of a cycle with 4 banks granted -> garb_avail_1h = 0 and garb_busy = 0 immediately. After release, ldg+sxt requesting -> ldg wins first.
